// File: rtl/escaner_teclado_pkg.sv
// Shared definitions for the keypad scanner.
//   - estado_e  : debounce FSM state encoding
//   - barrido_e : classification of one full 4-column sweep
//   - KeyW      : width of a key code (fila*4 + columna)
//   - col_drive : active-low one-hot column pattern for a column index
package escaner_teclado_pkg;

  localparam int unsigned KeyW    = 4;
  localparam int unsigned NumCols = 4;
  localparam int unsigned NumRows = 4;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StConfirm = 2'd1,
    StHeld    = 2'd2,
    StRelease = 2'd3
  } estado_e;

  typedef enum logic [1:0] {
    SweepNone   = 2'd0,
    SweepSingle = 2'd1,
    SweepMulti  = 2'd2
  } barrido_e;

  localparam logic [3:0] ColPat0 = 4'b1110;
  localparam logic [3:0] ColPat1 = 4'b1101;
  localparam logic [3:0] ColPat2 = 4'b1011;
  localparam logic [3:0] ColPat3 = 4'b0111;

  function automatic logic [3:0] col_drive(input logic [1:0] col);
    logic [3:0] pat;
    unique case (col)
      2'd0:    pat = ColPat0;
      2'd1:    pat = ColPat1;
      2'd2:    pat = ColPat2;
      default: pat = ColPat3;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/escaner_teclado_sincronizador_filas.sv
// Two-flop synchronizer for the asynchronous, active-low keypad rows.
// Reset value is all-ones so that rows read as "no key" while in reset.
//   clk_i    : system clock
//   rst_i    : asynchronous active-high reset
//   filas_i  : raw row inputs (asynchronous)
//   filas_o  : synchronized rows
module sincronizador_filas #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] filas_i,
  output logic [Width-1:0] filas_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= filas_i;
      sync_q <= meta_q;
    end
  end

  assign filas_o = sync_q;

endmodule

// File: rtl/escaner_teclado.sv
// 4x4 keypad scanner with sweep-level debouncing.
//   Clk         : system clock, rising edge
//   Rst         : asynchronous active-high reset
//   Columnas    : column drive, active-low one-hot, each held SCAN_TICKS cycles
//   Filas       : row sense, active-low, asynchronous
//   Tecla       : code of last accepted key (fila*4 + columna), kept after release
//   TeclaValida : one-cycle strobe per accepted press
//   Presionada  : high while the accepted key is held
module escaner_teclado
  import escaner_teclado_pkg::*;
#(
  parameter int unsigned SCAN_TICKS     = 100_000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic            Clk,
  input  logic            Rst,
  output logic [3:0]      Columnas,
  input  logic [3:0]      Filas,
  output logic [KeyW-1:0] Tecla,
  output logic            TeclaValida,
  output logic            Presionada
);

  localparam int unsigned     TickW     = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam logic [TickW-1:0] TickLast = TickW'(SCAN_TICKS - 1);
  localparam logic [3:0]      DebTarget = 4'(DEBOUNCE_SCANS);

  logic [3:0] filas_sync;

  sincronizador_filas #(
    .Width(4)
  ) u_sincronizador_filas (
    .clk_i  (Clk),
    .rst_i  (Rst),
    .filas_i(Filas),
    .filas_o(filas_sync)
  );

  // ---------------------------------------------------------------------------
  // Column scan and sweep classification
  // ---------------------------------------------------------------------------
  logic [TickW-1:0] tick_q, tick_d;
  logic [1:0]       col_q, col_d;
  logic [1:0]       hits_q, hits_d;       // 0, 1, or 2 meaning "two or more"
  logic [KeyW-1:0]  code_acc_q, code_acc_d;
  logic             sweep_done_q, sweep_done_d;
  barrido_e         clase_q, clase_d;
  logic [KeyW-1:0]  sweep_code_q, sweep_code_d;

  logic [1:0]       hits_n;
  logic [KeyW-1:0]  code_n;

  always_comb begin
    tick_d       = tick_q + 1'b1;
    col_d        = col_q;
    hits_d       = hits_q;
    code_acc_d   = code_acc_q;
    sweep_done_d = 1'b0;
    clase_d      = clase_q;
    sweep_code_d = sweep_code_q;
    hits_n       = hits_q;
    code_n       = code_acc_q;

    if (tick_q == TickLast) begin
      tick_d = '0;
      col_d  = col_q + 2'd1;

      // Merge this column's low rows into the running sweep tally.
      for (int r = 0; r < 4; r++) begin
        if (!filas_sync[r]) begin
          if (hits_n == 2'd0) code_n = {2'(r), col_q};
          if (hits_n != 2'd2) hits_n = hits_n + 2'd1;
        end
      end

      if (col_q == 2'd3) begin
        sweep_done_d = 1'b1;
        sweep_code_d = code_n;
        clase_d      = (hits_n == 2'd0) ? SweepNone :
                       (hits_n == 2'd1) ? SweepSingle : SweepMulti;
        hits_d       = '0;
        code_acc_d   = '0;
      end else begin
        hits_d     = hits_n;
        code_acc_d = code_n;
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      tick_q       <= '0;
      col_q        <= '0;
      hits_q       <= '0;
      code_acc_q   <= '0;
      sweep_done_q <= 1'b0;
      clase_q      <= SweepNone;
      sweep_code_q <= '0;
    end else begin
      tick_q       <= tick_d;
      col_q        <= col_d;
      hits_q       <= hits_d;
      code_acc_q   <= code_acc_d;
      sweep_done_q <= sweep_done_d;
      clase_q      <= clase_d;
      sweep_code_q <= sweep_code_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce FSM, evaluated once per sweep (cycle after the column-3 sample)
  // ---------------------------------------------------------------------------
  estado_e         estado_q, estado_d;
  logic [KeyW-1:0] cand_q, cand_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [3:0]      rcnt_q, rcnt_d;
  logic [KeyW-1:0] tecla_q, tecla_d;
  logic            valida_q, valida_d;
  logic            pres_q, pres_d;

  logic es_single;
  logic es_none;

  assign es_single = (clase_q == SweepSingle);
  assign es_none   = (clase_q == SweepNone);

  always_comb begin
    estado_d = estado_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    rcnt_d   = rcnt_q;
    tecla_d  = tecla_q;
    valida_d = 1'b0;
    pres_d   = pres_q;

    if (sweep_done_q) begin
      unique case (estado_q)
        StIdle: begin
          if (es_single) begin
            cand_d = sweep_code_q;
            if (DebTarget == 4'd1) begin
              estado_d = StHeld;
              tecla_d  = sweep_code_q;
              valida_d = 1'b1;
              pres_d   = 1'b1;
              cnt_d    = '0;
            end else begin
              estado_d = StConfirm;
              cnt_d    = 4'd1;
            end
          end
        end
        StConfirm: begin
          if (es_single && (sweep_code_q == cand_q)) begin
            if (cnt_q + 4'd1 == DebTarget) begin
              estado_d = StHeld;
              tecla_d  = cand_q;
              valida_d = 1'b1;
              pres_d   = 1'b1;
              cnt_d    = '0;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            estado_d = StIdle;
            cnt_d    = '0;
          end
        end
        StHeld: begin
          // SINGLE or MULTI here is rollover: keep holding, no new strobe.
          if (es_none) begin
            if (DebTarget == 4'd1) begin
              estado_d = StIdle;
              pres_d   = 1'b0;
              rcnt_d   = '0;
            end else begin
              estado_d = StRelease;
              rcnt_d   = 4'd1;
            end
          end
        end
        StRelease: begin
          if (es_none) begin
            if (rcnt_q + 4'd1 == DebTarget) begin
              estado_d = StIdle;
              pres_d   = 1'b0;
              rcnt_d   = '0;
            end else begin
              rcnt_d = rcnt_q + 4'd1;
            end
          end else begin
            estado_d = StHeld;
            rcnt_d   = '0;
          end
        end
        default: begin
          estado_d = StIdle;
          cnt_d    = '0;
          rcnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      estado_q <= StIdle;
      cand_q   <= '0;
      cnt_q    <= '0;
      rcnt_q   <= '0;
      tecla_q  <= '0;
      valida_q <= 1'b0;
      pres_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      rcnt_q   <= rcnt_d;
      tecla_q  <= tecla_d;
      valida_q <= valida_d;
      pres_q   <= pres_d;
    end
  end

  assign Columnas    = col_drive(col_q);
  assign Tecla       = tecla_q;
  assign TeclaValida = valida_q;
  assign Presionada  = pres_q;

endmodule

// File: tb/tb_escaner_teclado.sv
// Directed bench for escaner_teclado with SCAN_TICKS=8, DEBOUNCE_SCANS=3.
// A key mask (bit k = key k pressed) drives Filas from the current Columnas,
// emulating a passive keypad matrix.
module tb_escaner_teclado;

  localparam int unsigned Ticks = 8;
  localparam int unsigned Sweep = 4 * Ticks;

  logic       Clk;
  logic       Rst;
  logic [3:0] Columnas;
  logic [3:0] Filas;
  logic [3:0] Tecla;
  logic       TeclaValida;
  logic       Presionada;

  logic [15:0] mask;
  int          checks;
  int          errors;
  int          pulse_cnt;
  int          low_cnt;

  escaner_teclado #(
    .SCAN_TICKS    (Ticks),
    .DEBOUNCE_SCANS(3)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Columnas   (Columnas),
    .Filas      (Filas),
    .Tecla      (Tecla),
    .TeclaValida(TeclaValida),
    .Presionada (Presionada)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Keypad matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    Filas = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (mask[r*4+c] && !Columnas[c]) Filas[r] = 1'b0;
      end
    end
  end

  always @(posedge Clk) begin
    if (TeclaValida) pulse_cnt <= pulse_cnt + 1;
    if (!Presionada) low_cnt <= low_cnt + 1;
  end

  typedef struct {
    logic [15:0] mask;
    int          sweeps;
    int          pulses;
    logic        pres;
    logic [3:0]  tecla;
    logic        stable;  // Presionada must stay high for the whole step
  } step_t;

  step_t steps[20];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Steps start 2 cycles into a sweep so the previous sweep's strobe lands
  // inside the step that produced it.
  task automatic apply_step(input step_t s, input string tag);
    int p0;
    int l0;
    mask = s.mask;
    p0   = pulse_cnt;
    l0   = low_cnt;
    repeat (s.sweeps * Sweep) @(posedge Clk);
    #1;
    check({tag, " pulses"}, pulse_cnt - p0, s.pulses);
    check({tag, " presionada"}, int'(Presionada), int'(s.pres));
    check({tag, " tecla"}, int'(Tecla), int'(s.tecla));
    if (s.stable) check({tag, " presionada low cycles"}, low_cnt - l0, 0);
  endtask

  task automatic release_reset();
    @(negedge Clk);
    Rst = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    pulse_cnt = 0;
    low_cnt   = 0;
    mask      = '0;
    Rst       = 1'b0;

    //            mask      sw pul pres tecla stable
    // clean press / release of key 9
    steps[0]  = '{16'h0200, 3, 1, 1'b1, 4'd9,  1'b0};
    steps[1]  = '{16'h0200, 2, 0, 1'b1, 4'd9,  1'b1};
    steps[2]  = '{16'h0000, 2, 0, 1'b1, 4'd9,  1'b1};
    steps[3]  = '{16'h0000, 1, 0, 1'b0, 4'd9,  1'b0};
    // bounce on key 5: 2 present, 1 absent, 2 present
    steps[4]  = '{16'h0020, 2, 0, 1'b0, 4'd9,  1'b0};
    steps[5]  = '{16'h0000, 1, 0, 1'b0, 4'd9,  1'b0};
    steps[6]  = '{16'h0020, 2, 0, 1'b0, 4'd9,  1'b0};
    steps[7]  = '{16'h0000, 1, 0, 1'b0, 4'd9,  1'b0};
    // multi-key: 0 and 15 (different columns), then 1 and 5 (same column)
    steps[8]  = '{16'h8001, 10, 0, 1'b0, 4'd9, 1'b0};
    steps[9]  = '{16'h0022, 4, 0, 1'b0, 4'd9,  1'b0};
    // rollover and release glitch on key 3
    steps[10] = '{16'h0008, 3, 1, 1'b1, 4'd3,  1'b0};
    steps[11] = '{16'h1008, 3, 0, 1'b1, 4'd3,  1'b1};
    steps[12] = '{16'h0000, 2, 0, 1'b1, 4'd3,  1'b1};
    steps[13] = '{16'h0008, 2, 0, 1'b1, 4'd3,  1'b1};
    steps[14] = '{16'h1000, 2, 0, 1'b1, 4'd3,  1'b1};
    steps[15] = '{16'h0000, 3, 0, 1'b0, 4'd3,  1'b0};
    // code boundaries 15 and 0
    steps[16] = '{16'h8000, 3, 1, 1'b1, 4'd15, 1'b0};
    steps[17] = '{16'h0000, 3, 0, 1'b0, 4'd15, 1'b0};
    steps[18] = '{16'h0001, 3, 1, 1'b1, 4'd0,  1'b0};
    steps[19] = '{16'h0000, 3, 0, 1'b0, 4'd0,  1'b0};

    // Initial reset
    #2 Rst = 1'b1;
    #2;
    check("init columnas", int'(Columnas), 4'b1110);
    check("init tecla", int'(Tecla), 0);
    check("init valida", int'(TeclaValida), 0);
    check("init presionada", int'(Presionada), 0);
    repeat (3) @(posedge Clk);
    release_reset();

    for (int i = 0; i < 20; i++) apply_step(steps[i], $sformatf("step%0d", i));

    // Reset asserted mid-run, between clock edges, while key 9 is held.
    apply_step('{16'h0200, 3, 1, 1'b1, 4'd9, 1'b0}, "pre-reset press");
    repeat (40) @(posedge Clk);
    #1;
    check("pre-reset columnas", int'(Columnas), 4'b1101);
    #3 Rst = 1'b1;
    #1;
    check("async reset columnas", int'(Columnas), 4'b1110);
    check("async reset tecla", int'(Tecla), 0);
    check("async reset valida", int'(TeclaValida), 0);
    check("async reset presionada", int'(Presionada), 0);
    mask = '0;
    repeat (3) @(posedge Clk);
    release_reset();
    check("restart columnas col0", int'(Columnas), 4'b1110);

    // Reset during debounce: key 6 reaches CONFIRM cnt=2, reset, keep holding.
    apply_step('{16'h0040, 2, 0, 1'b0, 4'd0, 1'b0}, "confirm cnt2");
    Rst = 1'b1;
    repeat (4) @(posedge Clk);
    #1;
    check("debounce reset presionada", int'(Presionada), 0);
    release_reset();
    repeat (6) @(posedge Clk);
    #1;
    check("restart columnas col1", int'(Columnas), 4'b1101);
    repeat (Sweep - 6) @(posedge Clk);
    #1;
    check("after reset sweep1 tecla", int'(Tecla), 0);
    apply_step('{16'h0040, 1, 0, 1'b0, 4'd0, 1'b0}, "after reset sweep2");
    apply_step('{16'h0040, 1, 1, 1'b1, 4'd6, 1'b0}, "after reset sweep3");
    apply_step('{16'h0000, 3, 0, 1'b0, 4'd6, 1'b0}, "final release");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/escaner_teclado.md
ESCANER_TECLADO -- requirements
Module: escaner_teclado

Interface
REQ-001 SHALL have parameter SCAN_TICKS, default 100_000, Clk cycles each column is driven; legal values are 4 or more.
REQ-002 SHALL have parameter DEBOUNCE_SCANS, default 4, consecutive identical full sweeps needed to accept a press or a release; legal range 1..15.
REQ-003 SHALL have port Clk, input, 1 bit, the single system clock; all logic on its rising edge.
REQ-004 SHALL have port Rst, input, 1 bit, reset; asynchronous and active-high.
REQ-005 SHALL have port Columnas, output, 4 bits, keypad column drive; active-low one-hot.
REQ-006 SHALL have port Filas, input, 4 bits, keypad row sense; active-low, asynchronous to Clk.
REQ-007 SHALL have port Tecla, output, 4 bits, code of the last accepted key; code = fila*4 + columna.
REQ-008 SHALL have port TeclaValida, output, 1 bit, one-cycle strobe per accepted press.
REQ-009 SHALL have port Presionada, output, 1 bit, level that is high while the accepted key is held.

Function
REQ-010 SHALL pass Filas through a 2-flop synchronizer before any use.
REQ-011 SHALL hold each column low for exactly SCAN_TICKS cycles, in the order 1110, 1101, 1011, 0111, then wrap to 1110.
REQ-012 SHALL sample the synchronized rows once per column, on tick SCAN_TICKS-1 of that column's slot.
REQ-013 SHALL classify each full 4-column sweep as NONE (no low row), SINGLE(code) (exactly one low row-column intersection) or MULTI (two or more); MULTI is treated as NONE for acceptance.
REQ-014 SHALL evaluate the FSM once per sweep, on the cycle after the column-3 sample.
REQ-015 SHALL implement FSM states IDLE, CONFIRM, HELD and RELEASE.
REQ-016 IDLE: on SINGLE(k), SHALL move to CONFIRM with cand=k and cnt=1; otherwise SHALL stay in IDLE.
REQ-017 CONFIRM: on SINGLE(cand), SHALL increment cnt, and when cnt reaches DEBOUNCE_SCANS SHALL move to HELD; on any other result SHALL return to IDLE with cnt cleared.
REQ-018 With DEBOUNCE_SCANS=1, the first SINGLE sweep in IDLE SHALL move directly to HELD.
REQ-019 On entry to HELD: Tecla SHALL load cand, TeclaValida SHALL be high for exactly one cycle (the cycle after the evaluation), and Presionada SHALL go high.
REQ-020 HELD: on NONE, SHALL move to RELEASE with rcnt=1; on any SINGLE or MULTI (rollover), SHALL stay in HELD with no new strobe.
REQ-021 RELEASE: on NONE, SHALL increment rcnt, and when rcnt reaches DEBOUNCE_SCANS SHALL go to IDLE with Presionada low; on anything else SHALL return to HELD with no strobe.
REQ-022 Tecla SHALL retain its value after release until the next accepted press.
REQ-023 Tick, column and debounce counters SHALL wrap or clear without overflow glitches.

Reset
REQ-024 Asserting Rst SHALL immediately force: Columnas=1110, Tecla=0, TeclaValida=0, Presionada=0, state IDLE, all counters and the synchronizer at 0/idle (rows read as all-high).
REQ-025 Rst asserted mid-debounce or in HELD SHALL discard the candidate; no strobe SHALL be produced for that key after release of Rst.
REQ-026 After Rst deasserts, scanning SHALL restart at column 0, tick 0.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding, the column one-hot patterns, the key-code width (4) and the sweep-class encoding.
REQ-028 The 2-flop synchronizer SHALL be a separate sub-module, sincronizador_filas (4 bits wide, with reset).

Verification
REQ-029 The bench SHALL run with SCAN_TICKS=8 and DEBOUNCE_SCANS=3 (32 cycles per sweep).
REQ-030 Reset check: assert Rst mid-run -> outputs match REQ-024 with no clock edge needed.
REQ-031 Clean press and release: hold key fila 2 / columna 1 (pull Filas[2] low only while Columnas=1101) from tick 0 -> exactly one TeclaValida pulse after the 3rd full sweep, Tecla=9, Presionada=1. Release -> Presionada=0 after 3 NONE sweeps; Tecla stays 9.
REQ-032 Bounce rejection: key 5 present for 2 sweeps, absent for 1, present for 2 -> no TeclaValida pulse.
REQ-033 Multi-key rejection: keys 0 and 15 held together for 10 sweeps -> no pulse and Presionada=0.
REQ-034 Rollover and release glitch: while key 3 is accepted, add key 12, then drop all keys for 2 sweeps, then press key 3 again -> no extra pulse; Presionada stays 1 throughout.
REQ-035 Reset during debounce: assert Rst in CONFIRM with cnt=2, release Rst with the key still held -> pulse only after 3 new full sweeps; Tecla=0 until then.
